// File: rtl/example_seq_pkg.sv
// example_seq_pkg: shared types for the job sequencer (states, completion codes, job descriptor).
package example_seq_pkg;
  localparam int SEQ_ADDR_W  = 8;
  localparam int SEQ_DATA_W  = 32;
  localparam int SEQ_COUNT_W = 16;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_START,
    S_STREAM,
    S_DRAIN,
    S_CLEAR,
    S_REPORT
  } seq_state_e;
  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_CORE_ERR = 2'b01,
    ST_TIMEOUT  = 2'b10,
    ST_BAD_LEN  = 2'b11
  } cmp_status_e;
  typedef struct packed {
    logic [SEQ_ADDR_W-1:0]  addr;
    logic [SEQ_DATA_W-1:0]  data;
    logic [SEQ_COUNT_W-1:0] len;
  } seq_job_t;
  function automatic logic core_owned(seq_state_e s);
    return s inside {S_CONFIG, S_START, S_STREAM, S_DRAIN};
  endfunction
endpackage

// File: rtl/example_seq_watchdog.sv
// example_seq_watchdog: progress-timeout counter; expired_o flags the TIMEOUT_CYCLES-th idle run cycle.
module example_seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear_i ? '0 : (run_i && cnt_q != W'(TIMEOUT_CYCLES)) ? cnt_q + 1'b1 : cnt_q;
  // expiry ignores clear_i so the FSM can use it without a combinational loop
  assign expired_o = run_i && (cnt_q >= W'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/example_sequencer.sv
// example_sequencer: job-level controller that configures, starts, feeds and reports on example_core.
module example_sequencer
  import example_seq_pkg::*;
#(
  parameter int DATA_WIDTH     = SEQ_DATA_W,
  parameter int ADDR_WIDTH     = SEQ_ADDR_W,
  parameter int COUNT_WIDTH    = SEQ_COUNT_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   job_valid_i,
  output logic                   job_ready_o,
  input  logic [ADDR_WIDTH-1:0]  job_cfg_addr_i,
  input  logic [DATA_WIDTH-1:0]  job_cfg_data_i,
  input  logic [COUNT_WIDTH-1:0] job_len_i,
  input  logic [DATA_WIDTH-1:0]  src_data_i,
  input  logic                   src_valid_i,
  output logic                   src_ready_o,
  output logic                   core_enable_o,
  output logic                   core_start_o,
  output logic                   core_clear_o,
  input  logic                   core_busy_i,
  input  logic                   core_done_i,
  input  logic                   core_error_i,
  output logic [DATA_WIDTH-1:0]  core_data_o,
  output logic                   core_valid_o,
  input  logic                   core_ready_i,
  output logic [ADDR_WIDTH-1:0]  core_cfg_addr_o,
  output logic [DATA_WIDTH-1:0]  core_cfg_data_o,
  output logic                   core_cfg_valid_o,
  input  logic                   core_cfg_ready_i,
  output logic                   cmp_valid_o,
  input  logic                   cmp_ready_i,
  output logic [1:0]             cmp_status_o,
  output logic [COUNT_WIDTH-1:0] cmp_count_o,
  output logic                   seq_busy_o
);
  seq_state_e             state_q, state_d;
  cmp_status_e            status_q, status_d;
  seq_job_t               job_q, job_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   stream, cfg_hs, data_hs, last, err, wd_expired, wd_run, wd_clear, unused;
  assign unused   = core_busy_i;
  assign stream   = state_q == S_STREAM;
  assign cfg_hs   = state_q == S_CONFIG && core_cfg_ready_i;
  assign data_hs  = stream && src_valid_i && core_ready_i;
  assign last     = data_hs && (cnt_q + 1'b1 == job_q.len);
  assign err      = core_owned(state_q) && core_error_i;
  assign wd_run   = state_q inside {S_CONFIG, S_STREAM, S_DRAIN};
  assign wd_clear = cfg_hs || data_hs || state_d != state_q;
  example_seq_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (wd_clear),
    .run_i    (wd_run),
    .expired_o(wd_expired)
  );
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    job_d    = job_q;
    cnt_d    = data_hs ? cnt_q + 1'b1 : cnt_q;
    case (state_q)
      S_IDLE:
        if (job_valid_i) begin
          job_d    = '{addr: job_cfg_addr_i, data: job_cfg_data_i, len: job_len_i};
          cnt_d    = '0;
          status_d = job_len_i == '0 ? ST_BAD_LEN : ST_OK;
          state_d  = job_len_i == '0 ? S_REPORT : S_CONFIG;
        end
      S_CONFIG: state_d = cfg_hs ? S_START : S_CONFIG;
      S_START:  state_d = S_STREAM;
      S_STREAM: state_d = last ? S_DRAIN : S_STREAM;
      S_DRAIN:  state_d = core_done_i ? S_REPORT : S_DRAIN;
      S_CLEAR:  state_d = S_REPORT;
      S_REPORT: state_d = cmp_ready_i ? S_IDLE : S_REPORT;
      default:  state_d = S_IDLE;
    endcase
    // any forward progress this cycle beats a simultaneous expiry
    if (wd_expired && !cfg_hs && !data_hs && state_d == state_q) begin
      state_d  = S_CLEAR;
      status_d = ST_TIMEOUT;
    end
    if (err) begin
      state_d  = S_CLEAR;
      status_d = ST_CORE_ERR;
    end
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q  <= S_IDLE;
      status_q <= ST_OK;
      job_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      job_q    <= job_d;
      cnt_q    <= cnt_d;
    end
  assign job_ready_o      = state_q == S_IDLE && !reset_i;
  assign core_enable_o    = core_owned(state_q);
  assign core_start_o     = state_q == S_START;
  assign core_clear_o     = state_q == S_CLEAR;
  assign core_cfg_valid_o = state_q == S_CONFIG;
  assign core_cfg_addr_o  = job_q.addr;
  assign core_cfg_data_o  = job_q.data;
  assign core_data_o      = stream ? src_data_i : '0;
  assign core_valid_o     = stream && src_valid_i;
  assign src_ready_o      = stream && core_ready_i;
  assign cmp_valid_o      = state_q == S_REPORT;
  assign cmp_status_o     = status_q;
  assign cmp_count_o      = cnt_q;
  assign seq_busy_o       = state_q != S_IDLE;
endmodule

// File: tb/tb_example_sequencer.sv
// tb_example_sequencer: directed self-checking bench for example_sequencer.
module tb_example_sequencer;
  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        job_valid_i = 1'b0, job_ready_o;
  logic [7:0]  job_cfg_addr_i = '0;
  logic [31:0] job_cfg_data_i = '0;
  logic [15:0] job_len_i = '0;
  logic [31:0] src_data_i = '0;
  logic        src_valid_i = 1'b0, src_ready_o;
  logic        core_enable_o, core_start_o, core_clear_o;
  logic        core_busy_i = 1'b0, core_done_i = 1'b0, core_error_i = 1'b0;
  logic [31:0] core_data_o;
  logic        core_valid_o, core_ready_i = 1'b1;
  logic [7:0]  core_cfg_addr_o;
  logic [31:0] core_cfg_data_o;
  logic        core_cfg_valid_o, core_cfg_ready_i = 1'b1;
  logic        cmp_valid_o, cmp_ready_i = 1'b0;
  logic [1:0]  cmp_status_o;
  logic [15:0] cmp_count_o;
  logic        seq_busy_o;
  int errors = 0, checks = 0;
  int cfg_n = 0, start_n = 0, clear_n = 0, act_n = 0, cmpv_n = 0;
  logic [31:0] cfg_last = '0;
  logic [31:0] words[$];

  example_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .COUNT_WIDTH(16), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_cfg_addr_i(job_cfg_addr_i), .job_cfg_data_i(job_cfg_data_i), .job_len_i(job_len_i),
    .src_data_i(src_data_i), .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .core_enable_o(core_enable_o), .core_start_o(core_start_o), .core_clear_o(core_clear_o),
    .core_busy_i(core_busy_i), .core_done_i(core_done_i), .core_error_i(core_error_i),
    .core_data_o(core_data_o), .core_valid_o(core_valid_o), .core_ready_i(core_ready_i),
    .core_cfg_addr_o(core_cfg_addr_o), .core_cfg_data_o(core_cfg_data_o),
    .core_cfg_valid_o(core_cfg_valid_o), .core_cfg_ready_i(core_cfg_ready_i),
    .cmp_valid_o(cmp_valid_o), .cmp_ready_i(cmp_ready_i),
    .cmp_status_o(cmp_status_o), .cmp_count_o(cmp_count_o), .seq_busy_o(seq_busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i)
    if (!reset_i) begin
      if (core_valid_o && core_ready_i) words.push_back(core_data_o);
      if (core_cfg_valid_o && core_cfg_ready_i) begin
        cfg_n++;
        cfg_last = core_cfg_data_o;
      end
      if (core_start_o) start_n++;
      if (core_clear_o) clear_n++;
      if (core_enable_o || core_cfg_valid_o || core_start_o || core_clear_o) act_n++;
      if (cmp_valid_o) cmpv_n++;
    end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic submit(input logic [7:0] a, input logic [31:0] d, input logic [15:0] l);
    job_cfg_addr_i = a;
    job_cfg_data_i = d;
    job_len_i = l;
    job_valid_i = 1'b1;
    #1;
    chk("job_ready_before_accept", job_ready_o, 1);
    tick();
    job_valid_i = 1'b0;
  endtask

  task automatic report_hs();
    cmp_ready_i = 1'b1;
    tick();
    cmp_ready_i = 1'b0;
    #1;
    chk("idle_after_report", job_ready_o, 1);
    chk("cmp_valid_dropped", cmp_valid_o, 0);
  endtask

  initial begin
    int base, k, gap, c0, s0, a0, m0;
    #2;
    chk("rst_job_ready", job_ready_o, 0);
    chk("rst_busy", seq_busy_o, 0);
    chk("rst_cmp_valid", cmp_valid_o, 0);
    chk("rst_enable", core_enable_o, 0);
    chk("rst_src_ready", src_ready_o, 0);
    tick();
    reset_i = 1'b0;
    #1;
    chk("post_rst_job_ready", job_ready_o, 1);

    // normal job
    base = words.size();
    submit(8'h00, 32'hA5A5_A5A5, 16'd4);
    #1;
    chk("n_cfg_valid", core_cfg_valid_o, 1);
    chk("n_cfg_data", core_cfg_data_o, 32'hA5A5_A5A5);
    chk("n_cfg_addr", core_cfg_addr_o, 8'h00);
    chk("n_enable_cfg", core_enable_o, 1);
    chk("n_job_ready_busy", job_ready_o, 0);
    tick();
    chk("n_start", core_start_o, 1);
    chk("n_cfg_valid_off", core_cfg_valid_o, 0);
    tick();
    chk("n_start_one_cycle", core_start_o, 0);
    chk("n_src_ready", src_ready_o, 1);
    for (int i = 0; i < 4; i++) begin
      src_valid_i = 1'b1;
      src_data_i = 32'h1000 + 32'(i);
      #1;
      chk("n_passthru", core_data_o, 32'h1000 + 32'(i));
      tick();
    end
    src_valid_i = 1'b0;
    #1;
    chk("n_drain_src_ready", src_ready_o, 0);
    chk("n_drain_core_valid", core_valid_o, 0);
    tick();
    chk("n_drain_wait", cmp_valid_o, 0);
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
    chk("n_cmp_valid", cmp_valid_o, 1);
    chk("n_status", cmp_status_o, 2'b00);
    chk("n_count", cmp_count_o, 4);
    tick();
    chk("n_hold_valid", cmp_valid_o, 1);
    chk("n_hold_count", cmp_count_o, 4);
    chk("n_cfg_writes", cfg_n, 1);
    chk("n_cfg_last", cfg_last, 32'hA5A5_A5A5);
    chk("n_starts", start_n, 1);
    chk("n_word_count", words.size() - base, 4);
    for (int i = 0; i < 4; i++) chk("n_word", words[base+i], 32'h1000 + 32'(i));
    report_hs();

    // back-pressure
    base = words.size();
    k = 0;
    gap = 0;
    submit(8'h00, 32'hA5A5_A5A5, 16'd4);
    for (int c = 0; c < 300 && !cmp_valid_o; c++) begin
      core_ready_i = c[0];
      core_done_i = (words.size() - base == 4);
      if (gap > 0) begin
        src_valid_i = 1'b0;
        gap--;
      end else if (k < 4) begin
        src_valid_i = 1'b1;
        src_data_i = 32'h2000 + 32'(k);
      end else src_valid_i = 1'b0;
      tick();
      if (words.size() - base > k) begin
        k++;
        gap = 3;
      end
    end
    core_done_i = 1'b0;
    src_valid_i = 1'b0;
    core_ready_i = 1'b1;
    chk("bp_completed", cmp_valid_o, 1);
    chk("bp_status", cmp_status_o, 2'b00);
    chk("bp_count", cmp_count_o, 4);
    chk("bp_word_count", words.size() - base, 4);
    for (int i = 0; i < 4 && base + i < words.size(); i++) chk("bp_word", words[base+i], 32'h2000 + 32'(i));
    report_hs();

    // core error after word 2
    c0 = clear_n;
    submit(8'h11, 32'h0000_0001, 16'd4);
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      src_valid_i = 1'b1;
      src_data_i = 32'h3000 + 32'(i);
      tick();
    end
    src_valid_i = 1'b0;
    tick();
    core_error_i = 1'b1;
    #1;
    chk("e_src_ready_before", src_ready_o, 1);
    tick();
    core_error_i = 1'b0;
    chk("e_clear", core_clear_o, 1);
    chk("e_enable_off", core_enable_o, 0);
    chk("e_src_ready_drop", src_ready_o, 0);
    chk("e_no_cmp_yet", cmp_valid_o, 0);
    tick();
    chk("e_clear_one_cycle", core_clear_o, 0);
    chk("e_cmp_valid", cmp_valid_o, 1);
    chk("e_status", cmp_status_o, 2'b01);
    chk("e_count", cmp_count_o, 2);
    chk("e_clear_pulses", clear_n - c0, 1);
    report_hs();

    // timeout with config never accepted
    core_cfg_ready_i = 1'b0;
    submit(8'h22, 32'h0000_0002, 16'd4);
    for (int i = 0; i < 15; i++) tick();
    chk("t_still_config", core_cfg_valid_o, 1);
    chk("t_no_clear_yet", core_clear_o, 0);
    tick();
    chk("t_clear", core_clear_o, 1);
    chk("t_cfg_valid_off", core_cfg_valid_o, 0);
    tick();
    chk("t_cmp_valid", cmp_valid_o, 1);
    chk("t_status", cmp_status_o, 2'b10);
    chk("t_count", cmp_count_o, 0);
    report_hs();
    core_cfg_ready_i = 1'b1;

    // zero length
    a0 = act_n;
    submit(8'h33, 32'h0000_0003, 16'd0);
    chk("b_cmp_valid", cmp_valid_o, 1);
    chk("b_status", cmp_status_o, 2'b11);
    chk("b_count", cmp_count_o, 0);
    chk("b_busy", seq_busy_o, 1);
    chk("b_enable", core_enable_o, 0);
    tick();
    chk("b_no_core_activity", act_n - a0, 0);
    report_hs();

    // done and error together in DRAIN
    submit(8'h44, 32'h0000_0004, 16'd1);
    tick();
    tick();
    src_valid_i = 1'b1;
    src_data_i = 32'h4000;
    tick();
    src_valid_i = 1'b0;
    core_done_i = 1'b1;
    core_error_i = 1'b1;
    tick();
    core_done_i = 1'b0;
    core_error_i = 1'b0;
    chk("de_clear", core_clear_o, 1);
    chk("de_no_cmp", cmp_valid_o, 0);
    tick();
    chk("de_status", cmp_status_o, 2'b01);
    chk("de_count", cmp_count_o, 1);
    report_hs();

    // reset during STREAM
    submit(8'h55, 32'h0000_0005, 16'd4);
    tick();
    tick();
    src_valid_i = 1'b1;
    src_data_i = 32'h5000;
    tick();
    src_data_i = 32'h5555;
    m0 = cmpv_n;
    s0 = clear_n;
    reset_i = 1'b1;
    #1;
    chk("r_job_ready", job_ready_o, 0);
    chk("r_enable", core_enable_o, 0);
    chk("r_src_ready", src_ready_o, 0);
    chk("r_core_valid", core_valid_o, 0);
    chk("r_core_data", core_data_o, 0);
    chk("r_busy", seq_busy_o, 0);
    chk("r_count", cmp_count_o, 0);
    chk("r_cfg_data", core_cfg_data_o, 0);
    tick();
    tick();
    src_valid_i = 1'b0;
    reset_i = 1'b0;
    #1;
    chk("r_job_ready_after", job_ready_o, 1);
    chk("r_cmp_valid", cmp_valid_o, 0);
    tick();
    chk("r_no_cmp_record", cmpv_n - m0, 0);
    chk("r_no_clear_pulse", clear_n - s0, 0);
    base = words.size();
    submit(8'h66, 32'h0000_0006, 16'd1);
    tick();
    tick();
    src_valid_i = 1'b1;
    src_data_i = 32'h6000;
    tick();
    src_valid_i = 1'b0;
    core_done_i = 1'b1;
    #1;
    chk("r2_not_yet", cmp_valid_o, 0);
    tick();
    core_done_i = 1'b0;
    chk("r2_cmp_valid", cmp_valid_o, 1);
    chk("r2_status", cmp_status_o, 2'b00);
    chk("r2_count", cmp_count_o, 1);
    chk("r2_words", words.size() - base, 1);
    if (words.size() > base) chk("r2_word", words[base], 32'h6000);
    report_hs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "bench time limit exceeded");
  end
endmodule
